caractere_reader: RTL

//  Reverse direction of the 5-bit character -> 7-segment decoder: samples a 7-segment pattern
//  (a..g), waits until it is stable, and recovers the 5-bit character code {A,B,C,D,E}.

---
 rtl/caractere_reader_pkg.sv | 32 +++
 rtl/caractere_reader_if.sv | 16 +
 rtl/caractere_reader_seg_lookup.sv | 22 ++
 rtl/caractere_reader.sv | 104 ++++++++++
 4 files changed

// File: rtl/caractere_reader_pkg.sv
// Shared constants for the character <-> 7-segment path: code->segment table,
// FSM state type and the "nothing emitted yet" sentinel.
package caractere_pkg;

  localparam int SEG_W  = 7;
  localparam int CODE_W = 5;

  typedef logic [SEG_W-1:0]  seg_t;
  typedef logic [CODE_W-1:0] code_t;

  // code -> {a..g}; same table the forward character decoder drives
  localparam seg_t CHAR_SEG [0:31] = '{
    7'b0000001, 7'b1001111, 7'b0010010, 7'b0000110,
    7'b1001100, 7'b0100100, 7'b0100000, 7'b0001111,
    7'b0000000, 7'b0000100, 7'b0001000, 7'b1100000,
    7'b0110001, 7'b1000010, 7'b0110000, 7'b0111000,
    7'b0100001, 7'b1001000, 7'b1000011, 7'b1110001,
    7'b1101010, 7'b1100010, 7'b0011000, 7'b0001100,
    7'b1111010, 7'b1110000, 7'b1000001, 7'b1000100,
    7'b1111110, 7'b1110111, 7'b1101000, 7'b1100011
  };

  typedef enum logic [1:0] {
    ST_SETTLE,
    ST_LOOKUP,
    ST_PRESENT
  } state_e;

  // one bit wider than a pattern so it can never equal a real sample
  localparam logic [SEG_W:0] SEG_NONE = {1'b1, {SEG_W{1'b0}}};

endpackage

// File: rtl/caractere_reader_if.sv
// Segment input and recovered-code handshake bundle for caractere_reader.
interface caractere_reader_if;
  import caractere_pkg::*;

  seg_t  seg_in;
  code_t code_out;
  logic  code_err;
  logic  code_valid;
  logic  code_ready;
  logic  busy;

  modport master (output seg_in, code_ready,
                  input  code_out, code_err, code_valid, busy);
  modport slave  (input  seg_in, code_ready,
                  output code_out, code_err, code_valid, busy);
endinterface

// File: rtl/caractere_reader_seg_lookup.sv
// Combinational reverse lookup: segment pattern -> {hit, code}, lowest code wins.
module seg_lookup
  import caractere_pkg::*;
(
  input  seg_t  pat_i,
  output logic  hit_o,
  output code_t code_o
);

  // scan downward so the lowest matching code is the last one written
  always_comb begin
    hit_o  = 1'b0;
    code_o = '0;
    for (int i = 31; i >= 0; i--) begin
      if (pat_i == CHAR_SEG[i]) begin
        hit_o  = 1'b1;
        code_o = CODE_W'(i);
      end
    end
  end

endmodule

// File: rtl/caractere_reader.sv
// Debounced 7-segment -> character code reader with valid/ready output.
// Optional: SEG_ACTIVE_LOW_EN inverts seg_in at the input register.
module caractere_reader
  import caractere_pkg::*;
#(
  parameter int STABLE_CYCLES = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  caractere_reader_if.slave        bus
);

  localparam int CW = $clog2(STABLE_CYCLES + 1);
  localparam logic [CW-1:0] CNT_MAX = CW'(STABLE_CYCLES);

  seg_t            seg_d, seg_q;
  logic [CW-1:0]   cnt_d, cnt_q;
  state_e          state_d, state_q;
  code_t           code_d, code_q;
  logic            err_d, err_q;
  logic            valid_d, valid_q;
  logic [SEG_W:0]  last_d, last_q;
  seg_t            pat_d, pat_q;
  logic            lk_hit;
  code_t           lk_code;

`ifdef SEG_ACTIVE_LOW_EN
  assign seg_d = ~bus.seg_in;
`else
  assign seg_d = bus.seg_in;
`endif

  seg_lookup u_lookup (
    .pat_i  (pat_q),
    .hit_o  (lk_hit),
    .code_o (lk_code)
  );

  // counter runs in every state so a pattern stable during PRESENT is ready on return
  always_comb begin
    cnt_d = cnt_q;
    if (seg_d != seg_q)       cnt_d = '0;
    else if (cnt_q != CNT_MAX) cnt_d = cnt_q + 1'b1;
  end

  always_comb begin
    state_d = state_q;
    code_d  = code_q;
    err_d   = err_q;
    valid_d = valid_q;
    last_d  = last_q;
    pat_d   = pat_q;
    case (state_q)
      ST_SETTLE: begin
        if (cnt_q == CNT_MAX && {1'b0, seg_q} != last_q) begin
          pat_d   = seg_q;
          state_d = ST_LOOKUP;
        end
      end
      ST_LOOKUP: begin
        code_d  = lk_hit ? lk_code : '0;
        err_d   = ~lk_hit;
        valid_d = 1'b1;
        state_d = ST_PRESENT;
      end
      ST_PRESENT: begin
        if (bus.code_ready) begin
          valid_d = 1'b0;
          last_d  = {1'b0, pat_q};
          state_d = ST_SETTLE;
        end
      end
      default: state_d = ST_SETTLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      seg_q   <= '0;
      cnt_q   <= '0;
      state_q <= ST_SETTLE;
      code_q  <= '0;
      err_q   <= 1'b0;
      valid_q <= 1'b0;
      last_q  <= SEG_NONE;
      pat_q   <= '0;
    end else begin
      seg_q   <= seg_d;
      cnt_q   <= cnt_d;
      state_q <= state_d;
      code_q  <= code_d;
      err_q   <= err_d;
      valid_q <= valid_d;
      last_q  <= last_d;
      pat_q   <= pat_d;
    end
  end

  assign bus.code_out   = code_q;
  assign bus.code_err   = err_q;
  assign bus.code_valid = valid_q;
  assign bus.busy       = (state_q != ST_SETTLE);

endmodule
